upsample: RTL

- Nearest-neighbour temporal upsampler for the wake-word datapath; the inverse of the 2:1 max-pool stage.
- Accepts one signed sample per input handshake and replays it FACTOR times on the output stream.
- Preserves frame boundaries: last_o accompanies the final replica of the last_i sample.
- Used to re-expand a pooled feature stream to the original frame rate, e.g. for alignment or debug taps.

---
 rtl/upsample.sv | 110 +++++++++++
 1 files changed

// File: rtl/upsample.sv
// Nearest-neighbour temporal upsampler.
//
// Accepts one signed sample per input handshake and replays it FACTOR times on the
// output stream. last_o accompanies only the final replica of a sample that arrived
// with last_i set. A new sample may be accepted in the same cycle as the final beat
// of the previous one, so full rate is sustained.
//
// Ports:
//   clk_i    - clock, all state on rising edge
//   rst_n_i  - asynchronous active-low reset
//   data_i   - signed input sample (BW bits)
//   valid_i  - input sample valid
//   last_i   - input sample is final sample of frame
//   ready_o  - block can accept a sample this cycle
//   data_o   - signed output sample (registered)
//   valid_o  - output sample valid (registered)
//   last_o   - output beat is final beat of frame
//   ready_i  - downstream can accept this cycle
module upsample #(
    parameter int unsigned BW     = 8,
    parameter int          FACTOR = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic signed [BW-1:0] data_i,
    input  logic                 valid_i,
    input  logic                 last_i,
    output logic                 ready_o,
    output logic signed [BW-1:0] data_o,
    output logic                 valid_o,
    output logic                 last_o,
    input  logic                 ready_i
);

    localparam int CntW = (FACTOR > 1) ? $clog2(FACTOR) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(FACTOR - 1);

    if (FACTOR < 1) begin : gen_factor_check
        $error("upsample: FACTOR must be at least 1");
    end

    typedef enum logic [0:0] {StEmpty, StEmit} state_e;

    state_e                state_q, state_d;
    logic signed [BW-1:0]  data_q, data_d;
    logic                  last_q, last_d;
    logic [CntW-1:0]       cnt_q, cnt_d;

    logic at_end;
    logic accept;
    logic beat;

    assign at_end  = (cnt_q == LastCnt);
    assign valid_o = (state_q == StEmit);
    assign data_o  = data_q;
    assign last_o  = valid_o & last_q & at_end;

    // ready_i feeds ready_o combinationally so the final replica and the next
    // accept can share a cycle.
    assign ready_o = (state_q == StEmpty) | (ready_i & at_end);
    assign accept  = valid_i & ready_o;
    assign beat    = valid_o & ready_i;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StEmpty: begin
                if (accept) begin
                    state_d = StEmit;
                    data_d  = data_i;
                    last_d  = last_i;
                    cnt_d   = '0;
                end
            end
            StEmit: begin
                if (beat) begin
                    if (!at_end) begin
                        cnt_d = cnt_q + CntW'(1);
                    end else if (accept) begin
                        data_d = data_i;
                        last_d = last_i;
                        cnt_d  = '0;
                    end else begin
                        state_d = StEmpty;
                        cnt_d   = '0;
                    end
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= StEmpty;
            data_q  <= '0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
